// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared helpers and the request payload layout for mem_port_pipe.
// The payload struct is a macro so each instance picks its own widths.
`ifndef MEM_PORT_PKG_SV
`define MEM_PORT_PKG_SV

`define MEM_PORT_REQ_T(AW, DW, SW) \
  struct packed { \
    logic [AW-1:0] addr; \
    logic          we; \
    logic [DW-1:0] wdata; \
    logic [SW-1:0] strb; \
  }

package mem_port_pkg;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`endif

// File: rtl/mem_port_req_fifo.sv
// mem_port_req_fifo: request payload FIFO with registered storage.
// The head reads as zero while empty so idle downstream fields stay quiet.
module mem_port_req_fifo
  import mem_port_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = ptr_width(Depth);
  localparam int CntW = cnt_width(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_pipe.sv
// mem_port_pipe: timing-cut stage on one req/gnt + rvalid/rdata memory port.
// Define MEM_PORT_PIPE_RSP_REG_EN to add a one-cycle response register.
module mem_port_pipe
  import mem_port_pkg::*;
#(
  parameter  int AddrWidth      = 32,
  parameter  int DataWidth      = 64,
  localparam int StrbWidth      = DataWidth / 8,
  parameter  int ReqDepth       = 2,
  parameter  int MaxOutstanding = 8,
  localparam int CntWidth       = cnt_width(MaxOutstanding)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_req_i,
  output logic                 in_gnt_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic                 in_we_i,
  input  logic [DataWidth-1:0] in_wdata_i,
  input  logic [StrbWidth-1:0] in_strb_i,
  output logic                 in_rvalid_o,
  output logic [DataWidth-1:0] in_rdata_o,
  output logic                 out_req_o,
  input  logic                 out_gnt_i,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic                 out_we_o,
  output logic [DataWidth-1:0] out_wdata_o,
  output logic [StrbWidth-1:0] out_strb_o,
  input  logic                 out_rvalid_i,
  input  logic [DataWidth-1:0] out_rdata_i,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  outstanding_o
);

  typedef `MEM_PORT_REQ_T(AddrWidth, DataWidth, StrbWidth) mem_req_payload_t;

  mem_req_payload_t    w_push_pl;
  mem_req_payload_t    w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_acc;
  logic                w_pop;
  logic                w_rsp_pending;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_nxt;

  assign w_push_pl.addr  = in_addr_i;
  assign w_push_pl.we    = in_we_i;
  assign w_push_pl.wdata = in_wdata_i;
  assign w_push_pl.strb  = in_strb_i;

  // Grant looks only at registered state, never at in_req_i.
  assign in_gnt_o = !w_full && (r_cnt < CntWidth'(MaxOutstanding));
  assign w_acc    = in_req_i && in_gnt_o;

  mem_port_req_fifo #(
    .Width ($bits(mem_req_payload_t)),
    .Depth (ReqDepth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_acc),
    .data_i  (w_push_pl),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign out_req_o   = !w_empty;
  assign w_pop       = out_req_o && out_gnt_i;
  assign out_addr_o  = w_head.addr;
  assign out_we_o    = w_head.we;
  assign out_wdata_o = w_head.wdata;
  assign out_strb_o  = w_head.strb;

`ifdef MEM_PORT_PIPE_RSP_REG_EN
  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= out_rvalid_i;
      if (out_rvalid_i) begin
        r_rdata <= out_rdata_i;
      end
    end
  end

  assign in_rvalid_o   = r_rvalid;
  assign in_rdata_o    = r_rdata;
  assign w_rsp_pending = r_rvalid;
`else
  assign in_rvalid_o   = out_rvalid_i;
  assign in_rdata_o    = out_rdata_i;
  assign w_rsp_pending = 1'b0;
`endif

  // A stray response at zero must not wrap the counter.
  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_acc, in_rvalid_o})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign outstanding_o = r_cnt;
  assign busy_o        = (r_cnt != '0) || !w_empty;

  a_no_orphan_rsp: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(out_rvalid_i && (r_cnt == '0) && !w_rsp_pending)
  );

endmodule

// File: tb/tb_mem_port_pipe.sv
// tb_mem_port_pipe: randomized scenario bench for mem_port_pipe.
// Scoreboards handshakes in order and models counts from accepted/answered events.
module tb_mem_port_pipe;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int PW = AW + 1 + DW + SW;
`ifdef MEM_PORT_PIPE_RSP_REG_EN
  localparam int RSPLAT = 1;
`else
  localparam int RSPLAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_req = 1'b0;
  logic          in_gnt;
  logic [AW-1:0] in_addr = '0;
  logic          in_we = 1'b0;
  logic [DW-1:0] in_wdata = '0;
  logic [SW-1:0] in_strb = '0;
  logic          in_rvalid;
  logic [DW-1:0] in_rdata;
  logic          out_req;
  logic          out_gnt = 1'b1;
  logic [AW-1:0] out_addr;
  logic          out_we;
  logic [DW-1:0] out_wdata;
  logic [SW-1:0] out_strb;
  logic          out_rvalid = 1'b0;
  logic [DW-1:0] out_rdata = '0;
  logic          busy;
  logic [3:0]    outstanding;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mem_port_pipe dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_req_i      (in_req),
    .in_gnt_o      (in_gnt),
    .in_addr_i     (in_addr),
    .in_we_i       (in_we),
    .in_wdata_i    (in_wdata),
    .in_strb_i     (in_strb),
    .in_rvalid_o   (in_rvalid),
    .in_rdata_o    (in_rdata),
    .out_req_o     (out_req),
    .out_gnt_i     (out_gnt),
    .out_addr_o    (out_addr),
    .out_we_o      (out_we),
    .out_wdata_o   (out_wdata),
    .out_strb_o    (out_strb),
    .out_rvalid_i  (out_rvalid),
    .out_rdata_i   (out_rdata),
    .busy_o        (busy),
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Downstream memory: auto mode answers one cycle after its grant.
  logic          mem_auto = 1'b1;
  logic          man_rvalid = 1'b0;
  logic [DW-1:0] man_rdata = '0;
  logic          use_fixed = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  logic          fire_q = 1'b0;

  always @(posedge clk) begin
    #2;
    if (mem_auto) begin
      out_rvalid = fire_q;
      if (fire_q) out_rdata = use_fixed ? fixed_rdata : {$urandom, $urandom};
    end else begin
      out_rvalid = man_rvalid;
      if (man_rvalid) out_rdata = man_rdata;
    end
  end

  // Monitor and reference model: counts derive from observed handshakes.
  logic [PW-1:0] acc_q[$];
  logic [PW-1:0] iss_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] drsp_q[$];
  int            rsp_cyc_q[$];
  int            drsp_cyc_q[$];
  int            m_out = 0, m_out_nx = 0;
  int            m_fifo = 0, m_fifo_nx = 0;

  always @(negedge clk) begin
    fire_q = out_req && out_gnt && !rst;
    m_out  = m_out_nx;
    m_fifo = m_fifo_nx;
    if (rst) begin
      m_out_nx  = 0;
      m_fifo_nx = 0;
    end else begin
      m_fifo_nx = m_fifo + int'(in_req && in_gnt) - int'(out_req && out_gnt);
      m_out_nx  = m_out + int'(in_req && in_gnt) - int'(in_rvalid);
      if (m_out_nx < 0) m_out_nx = 0;
      if (in_req && in_gnt) acc_q.push_back({in_addr, in_we, in_wdata, in_strb});
      if (out_req && out_gnt) iss_q.push_back({out_addr, out_we, out_wdata, out_strb});
      if (in_rvalid) begin
        rsp_q.push_back(in_rdata);
        rsp_cyc_q.push_back(cyc);
      end
      if (out_rvalid) begin
        drsp_q.push_back(out_rdata);
        drsp_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic new_payload();
    in_addr  = $urandom;
    in_we    = 1'($urandom);
    in_wdata = {$urandom, $urandom};
    in_strb  = 8'($urandom);
  endtask

  task automatic wait_idle(output int fall);
    fall = -1;
    for (int k = 0; k < 60; k++) begin
      smp();
      if (!busy) begin
        fall = cyc;
        break;
      end
      drv();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    n_chk++;
    if ({in_gnt, out_req, in_rvalid, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags gnt/req/rvalid/busy got %b want 1000",
               {in_gnt, out_req, in_rvalid, busy});
    end
    n_chk++;
    if (outstanding !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outstanding got %0d want 0", outstanding);
    end
    n_chk++;
    if ({out_addr, out_we, out_wdata, out_strb, in_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload got addr %h wdata %h rdata %h want 0",
               out_addr, out_wdata, in_rdata);
    end
  endtask

  task automatic test_single_read();
    int t0, rcyc, max_o;
    logic [DW-1:0] rdat;
    use_fixed = 1'b1;
    fixed_rdata = 64'hDEAD_BEEF;
    mem_auto = 1'b1;
    out_gnt = 1'b1;
    rcyc = -1;
    rdat = '0;
    max_o = 0;
    drv();
    t0 = cyc;
    in_req = 1'b1;
    in_addr = 32'h100;
    in_we = 1'b0;
    in_wdata = {$urandom, $urandom};
    in_strb = '1;
    smp();
    n_chk++;
    if (!(in_gnt === 1'b1 && outstanding === 4'd0)) begin
      n_fail++;
      $display("FAIL single_accept gnt %b outst %0d want 1/0", in_gnt, outstanding);
    end
    drv();
    in_req = 1'b0;
    smp();
    n_chk++;
    if (!(out_req === 1'b1 && out_addr === 32'h100 && out_we === 1'b0 && outstanding === 4'd1)) begin
      n_fail++;
      $display("FAIL single_issue req %b addr %h outst %0d want 1/100/1",
               out_req, out_addr, outstanding);
    end
    for (int k = 0; k < 8; k++) begin
      drv();
      smp();
      if (in_rvalid && rcyc < 0) begin
        rcyc = cyc - t0;
        rdat = in_rdata;
      end
      if (int'(outstanding) > max_o) max_o = int'(outstanding);
    end
    n_chk++;
    if (rcyc !== 2 + RSPLAT || rdat !== 64'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_rsp cycle %0d data %h want %0d/deadbeef", rcyc, rdat, 2 + RSPLAT);
    end
    n_chk++;
    if (max_o !== 1 || outstanding !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_count max %0d final %0d busy %b want 1/0/0", max_o, outstanding, busy);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a0, r0, d0, i0, drops, bad, last_rv, fall, ord;
    a0 = acc_q.size();
    i0 = iss_q.size();
    r0 = rsp_q.size();
    d0 = drsp_q.size();
    drops = 0;
    bad = 0;
    last_rv = -1;
    ord = 0;
    mem_auto = 1'b1;
    out_gnt = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drv();
      in_req = 1'b1;
      new_payload();
      in_we = 1'b1;
      smp();
      if (in_gnt !== 1'b1) drops++;
      if (int'(outstanding) != m_out || busy !== (m_out != 0 || m_fifo != 0)) bad++;
      if (in_gnt !== (m_fifo < 2 && m_out < 8)) bad++;
      if (in_rvalid) last_rv = cyc;
    end
    drv();
    in_req = 1'b0;
    fall = -1;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (in_rvalid) last_rv = cyc;
      if (int'(outstanding) != m_out) bad++;
      if (!busy) begin
        fall = cyc;
        break;
      end
      drv();
    end
    n_chk++;
    if (drops !== 0) begin
      n_fail++;
      $display("FAIL b2b_gnt_drops got %0d want 0", drops);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_model_cycles mismatching got %0d want 0", bad);
    end
    for (int k = 0; k < 16; k++) begin
      if (a0 + k >= acc_q.size() || i0 + k >= iss_q.size() ||
          r0 + k >= rsp_q.size() || d0 + k >= drsp_q.size()) ord++;
      else if (acc_q[a0+k] !== iss_q[i0+k] || rsp_q[r0+k] !== drsp_q[d0+k] ||
               rsp_cyc_q[r0+k] !== drsp_cyc_q[d0+k] + RSPLAT) ord++;
    end
    n_chk++;
    if (ord !== 0 || rsp_q.size() - r0 !== 16) begin
      n_fail++;
      $display("FAIL b2b_order bad %0d responses %0d want 0/16", ord, rsp_q.size() - r0);
    end
    n_chk++;
    if (fall !== last_rv + 1) begin
      n_fail++;
      $display("FAIL b2b_busy_fall cycle %0d want %0d", fall, last_rv + 1);
    end
  endtask

  task automatic test_gnt_stall();
    int a0, i0, unstable, fall, ord;
    logic acc, have;
    logic [AW-1:0] a_first;
    a0 = acc_q.size();
    i0 = iss_q.size();
    unstable = 0;
    have = 1'b0;
    a_first = '0;
    ord = 0;
    drv();
    out_gnt = 1'b0;
    in_req = 1'b1;
    new_payload();
    for (int k = 0; k < 10; k++) begin
      smp();
      acc = in_req && in_gnt;
      if (out_req) begin
        if (!have) begin
          a_first = out_addr;
          have = 1'b1;
        end else if (out_addr !== a_first) unstable++;
      end
      drv();
      if (acc) new_payload();
    end
    smp();
    n_chk++;
    if (acc_q.size() - a0 !== 2 || in_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_grants got %0d gnt %b want 2/0", acc_q.size() - a0, in_gnt);
    end
    n_chk++;
    if (unstable !== 0 || !have) begin
      n_fail++;
      $display("FAIL stall_addr_stable changes %0d seen %b want 0/1", unstable, have);
    end
    drv();
    out_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      smp();
      acc = in_req && in_gnt;
      drv();
      if (acc) break;
    end
    in_req = 1'b0;
    wait_idle(fall);
    for (int k = 0; k < 3; k++) begin
      if (a0 + k >= acc_q.size() || i0 + k >= iss_q.size()) ord++;
      else if (acc_q[a0+k] !== iss_q[i0+k]) ord++;
    end
    n_chk++;
    if (ord !== 0 || iss_q.size() - i0 !== 3 || fall < 0) begin
      n_fail++;
      $display("FAIL stall_drain bad %0d issued %0d idle %0d want 0/3/>=0",
               ord, iss_q.size() - i0, fall);
    end
  endtask

  task automatic test_max_outstanding();
    int a0, fall;
    logic acc;
    a0 = acc_q.size();
    mem_auto = 1'b0;
    man_rvalid = 1'b0;
    out_gnt = 1'b1;
    drv();
    in_req = 1'b1;
    new_payload();
    for (int k = 0; k < 14; k++) begin
      smp();
      acc = in_req && in_gnt;
      drv();
      if (acc) new_payload();
    end
    smp();
    n_chk++;
    if (acc_q.size() - a0 !== 8 || outstanding !== 4'd8 || in_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL max_cap grants %0d outst %0d gnt %b want 8/8/0",
               acc_q.size() - a0, outstanding, in_gnt);
    end
    drv();
    man_rvalid = 1'b1;
    man_rdata = {$urandom, $urandom};
    drv();
    man_rvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp();
      acc = in_req && in_gnt;
      drv();
      if (acc) new_payload();
    end
    in_req = 1'b0;
    smp();
    n_chk++;
    if (acc_q.size() - a0 !== 9 || outstanding !== 4'd8 || int'(outstanding) != m_out) begin
      n_fail++;
      $display("FAIL max_one_more grants %0d outst %0d want 9/8", acc_q.size() - a0, outstanding);
    end
    for (int k = 0; k < 8; k++) begin
      drv();
      man_rvalid = 1'b1;
      man_rdata = {$urandom, $urandom};
    end
    drv();
    man_rvalid = 1'b0;
    wait_idle(fall);
    n_chk++;
    if (fall < 0 || outstanding !== 4'd0) begin
      n_fail++;
      $display("FAIL max_drain idle %0d outst %0d want >=0/0", fall, outstanding);
    end
  endtask

  task automatic test_push_rsp_same();
    int n, fall;
    logic acc, both;
    mem_auto = 1'b0;
    man_rvalid = 1'b0;
    out_gnt = 1'b1;
    n = 0;
    drv();
    in_req = 1'b1;
    new_payload();
    for (int k = 0; k < 12; k++) begin
      smp();
      acc = in_req && in_gnt;
      drv();
      if (acc) begin
        n++;
        if (n == 5) break;
        new_payload();
      end
    end
    in_req = 1'b0;
    smp();
    n_chk++;
    if (outstanding !== 4'd5) begin
      n_fail++;
      $display("FAIL same_setup outst %0d want 5", outstanding);
    end
    drv();
    man_rvalid = 1'b1;
    man_rdata = {$urandom, $urandom};
    if (RSPLAT == 1) begin
      drv();
      man_rvalid = 1'b0;
    end
    in_req = 1'b1;
    new_payload();
    smp();
    both = in_req && in_gnt && in_rvalid;
    drv();
    in_req = 1'b0;
    man_rvalid = 1'b0;
    smp();
    n_chk++;
    if (both !== 1'b1 || outstanding !== 4'd5) begin
      n_fail++;
      $display("FAIL same_cycle both %b outst %0d want 1/5", both, outstanding);
    end
    for (int k = 0; k < 5; k++) begin
      drv();
      man_rvalid = 1'b1;
      man_rdata = {$urandom, $urandom};
    end
    drv();
    man_rvalid = 1'b0;
    wait_idle(fall);
    n_chk++;
    if (fall < 0 || outstanding !== 4'd0) begin
      n_fail++;
      $display("FAIL same_drain idle %0d outst %0d want >=0/0", fall, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0;
    man_rvalid = 1'b0;
    out_gnt = 1'b1;
    drv();
    in_req = 1'b1;
    new_payload();
    drv();
    in_req = 1'b0;
    drv();
    out_gnt = 1'b0;
    in_req = 1'b1;
    new_payload();
    drv();
    new_payload();
    drv();
    in_req = 1'b0;
    smp();
    n_chk++;
    if (outstanding !== 4'd3 || out_req !== 1'b1 || in_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_setup outst %0d req %b gnt %b want 3/1/0", outstanding, out_req, in_gnt);
    end
    drv();
    rst = 1'b1;
    drv();
    rst = 1'b0;
    smp();
    n_chk++;
    if ({out_req, in_gnt, busy} !== 3'b010 || outstanding !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_state req/gnt/busy %b outst %0d want 010/0",
               {out_req, in_gnt, busy}, outstanding);
    end
    out_gnt = 1'b1;
    mem_auto = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d want completion", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_gnt_stall();
    test_max_outstanding();
    test_push_rsp_same();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_pipe.md
Name: mem_port_pipe

Overview:
- Timing-cut pipeline stage on one memory-port (req/gnt + rvalid/rdata) link between an AXI-to-memory converter output and one memory island core request port.
- Registers the request path through a small FIFO and the response path through one register.
- Bounds outstanding transactions and exposes a busy indication.
- Instantiated once per converter port, so the island can sit physically far from the converters.

Parameters:
- AddrWidth, 32, address width of in_addr_i/out_addr_o.
- DataWidth, 64, read/write data width.
- StrbWidth, DataWidth/8, byte-strobe width (derived, not overridden).
- ReqDepth, 2, request FIFO entries; must be >= 2 (2 gives full throughput).
- MaxOutstanding, 8, max transactions granted upstream but not yet answered upstream; must be >= 1.
- CntWidth, $clog2(MaxOutstanding+1), width of outstanding_o (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_req_i  in  1  upstream request valid.
- in_gnt_o  out  1  upstream grant.
- in_addr_i  in  AddrWidth  request address.
- in_we_i  in  1  write enable.
- in_wdata_i  in  DataWidth  write data.
- in_strb_i  in  StrbWidth  byte strobes.
- in_rvalid_o  out  1  upstream response valid.
- in_rdata_o  out  DataWidth  upstream response data.
- out_req_o  out  1  downstream request valid.
- out_gnt_i  in  1  downstream grant.
- out_addr_o  out  AddrWidth  downstream address.
- out_we_o  out  1  downstream write enable.
- out_wdata_o  out  DataWidth  downstream write data.
- out_strb_o  out  StrbWidth  downstream strobes.
- out_rvalid_i  in  1  downstream response valid; may not be stalled.
- out_rdata_i  in  DataWidth  downstream response data.
- busy_o  out  1  outstanding_o != 0 or request FIFO non-empty.
- outstanding_o  out  CntWidth  current outstanding count.

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: FIFO empty; outstanding = 0; in_gnt_o = 1; out_req_o = 0; in_rvalid_o = 0; busy_o = 0; in_rdata_o = 0; out_* payload = 0.
- Grant:
  - in_gnt_o = !fifo_full && (outstanding < MaxOutstanding).
  - Driven from registered state only; no combinational path from in_req_i.
  - Protocol: a granted request must not depend on in_gnt_o rising. Upstream holds req + payload until gnt.
- Enqueue: on in_req_i && in_gnt_o, push {addr, we, wdata, strb}.
- Issue:
  - out_req_o = !fifo_empty; out_* fields = FIFO head, registered.
  - Pop on out_req_o && out_gnt_i.
  - No bypass, so minimum request latency is 1 cycle (accept in cycle N, visible downstream in N+1).
  - Simultaneous push and pop when full is not possible, because gnt is low when full.
  - Push and pop in the same cycle when non-full: count unchanged.
- Response path: in_rvalid_o/in_rdata_o = out_rvalid_i/out_rdata_i delayed one cycle (see optional feature). in_rdata_o holds its last value when rvalid is low.
- Ordering: strictly in-order. Every request (read or write) yields exactly one rvalid.
- Outstanding counter:
  - +1 on an upstream grant; −1 on in_rvalid_o.
  - Both in the same cycle: unchanged.
  - Saturates by construction at MaxOutstanding.
- Boundary: out_rvalid_i while outstanding == 0 (and no response in the register) is a protocol error. It is flagged by assertion and the response is still forwarded; the counter must not underflow (clamp at 0).
- Reset mid-operation: FIFO contents and counter are discarded. The downstream is required to be reset in the same cycle.

Optional Feature:
- Macro: MEM_PORT_PIPE_RSP_REG_EN.
- Defined: response register present, so response latency is downstream + 1 cycle.
- Undefined: in_rvalid_o/in_rdata_o are combinational pass-through of out_rvalid_i/out_rdata_i (0 added cycles). Counter rules are unchanged.

Decomposition:
- Package mem_port_pkg:
  - typedef mem_req_payload_t {addr, we, wdata, strb}, parameterised through localparams in the instantiating module or via a struct macro.
  - Function cnt_width(MaxOutstanding).
- One sub-module: mem_port_req_fifo (parameterised depth, push/pop/full/empty, synchronous active-high reset) holding the request payload.

Test Plan:
- Single read, addr 0x100, out_gnt_i tied 1, downstream rvalid 1 cycle after grant with rdata 0xDEAD_BEEF → out_req_o at cycle 1; in_rvalid_o at cycle 3 with 0xDEAD_BEEF (cycle 2 with macro undefined); outstanding 0→1→0.
- Back-to-back 16 writes, out_gnt_i = 1, 1-cycle memory → in_gnt_o stays 1 throughout (ReqDepth = 2, MaxOutstanding = 8); 16 rvalids in order; busy_o drops the cycle after the last rvalid.
- out_gnt_i = 0 for 10 cycles with in_req_i held → exactly 2 grants, then in_gnt_o = 0; out_addr_o stable; releasing gnt drains in order.
- Memory withholds rvalid, grants always → in_gnt_o falls after 8 grants, outstanding_o = 8; one rvalid → exactly one more grant allowed.
- Push and response in the same cycle at outstanding = 5 → outstanding stays 5.
- rst_i asserted with 3 outstanding and 2 FIFO entries → next cycle out_req_o = 0, outstanding_o = 0, in_gnt_o = 1, busy_o = 0.
